// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder
//   Watches a multiplexed, active-low 7-segment (FND) bus and recovers the hex
//   value shown on each digit. The bus is sampled every clock. A capture happens
//   once per stable period, after STABLE_CYCLES identical consecutive samples.
//   The captured pattern is then classified:
//     - no digit selected            : ignored
//     - one digit selected, legal hex: digit value stored, update pulse
//     - one digit selected, all off  : digit marked blank, update pulse
//     - one digit selected, other    : pattern_err pulse
//     - several digits selected      : sel_err pulse
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   fnd_sel      active-low digit enables (bit k low = digit k driven)
//   fnd_on       active-low segments {g,f,e,d,c,b,a}
//   digits_out   recovered hex, digit k at [4k+3:4k]
//   digit_valid  digit k holds a decoded hex value
//   digit_blank  last capture of digit k was all segments off
//   update       one-cycle pulse on a hex or blank capture
//   pattern_err  one-cycle pulse on an illegal segment pattern
//   sel_err      one-cycle pulse when more than one digit was selected
module fnd_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   fnd_sel,
  input  logic [6:0]              fnd_on,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    update,
  output logic                    pattern_err,
  output logic                    sel_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Returns {legal, value} for an active-low {g..a} pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: seg_decode = {1'b1, 4'h0};
      7'b1111001: seg_decode = {1'b1, 4'h1};
      7'b0100100: seg_decode = {1'b1, 4'h2};
      7'b0110000: seg_decode = {1'b1, 4'h3};
      7'b0011001: seg_decode = {1'b1, 4'h4};
      7'b0010010: seg_decode = {1'b1, 4'h5};
      7'b0000010: seg_decode = {1'b1, 4'h6};
      7'b1011000: seg_decode = {1'b1, 4'h7};
      7'b0000000: seg_decode = {1'b1, 4'h8};
      7'b0010000: seg_decode = {1'b1, 4'h9};
      7'b0001000: seg_decode = {1'b1, 4'hA};
      7'b0000011: seg_decode = {1'b1, 4'hB};
      7'b1000110: seg_decode = {1'b1, 4'hC};
      7'b0100001: seg_decode = {1'b1, 4'hD};
      7'b0000110: seg_decode = {1'b1, 4'hE};
      7'b0001110: seg_decode = {1'b1, 4'hF};
      default:    seg_decode = 5'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Sampling and stability window
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] sel_reg;
  logic [6:0]            on_reg;
  logic [CW-1:0]         cnt_reg;
  logic [CW-1:0]         cnt_next;
  logic                  cap_reg;

  // The incoming bus is compared with the last sample, so the counter reflects
  // how many consecutive identical samples exist including the one being taken.
  always_comb begin
    cnt_next = cnt_reg;
    if ({fnd_sel, fnd_on} != {sel_reg, on_reg}) begin
      cnt_next = CW'(1);
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg <= '1;
      on_reg  <= '1;
      cnt_reg <= '0;
      cap_reg <= 1'b0;
    end else begin
      sel_reg <= fnd_sel;
      on_reg  <= fnd_on;
      cnt_reg <= cnt_next;
      // Only the transition into saturation triggers, so a long hold captures once.
      cap_reg <= (cnt_next == CNT_MAX) && (cnt_reg != CNT_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // Classification of the captured sample (sel_reg/on_reg still hold it)
  // ---------------------------------------------------------------------------
  logic [3:0]    low_cnt;
  logic [IW-1:0] sel_idx;
  logic [4:0]    dec;
  logic          is_hex;
  logic          is_blank;
  logic          cap_one;
  logic          cap_multi;

  always_comb begin
    low_cnt = 4'd0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel_reg[i]) begin
        low_cnt = low_cnt + 4'd1;
        sel_idx = IW'(i);
      end
    end
  end

  assign dec       = seg_decode(on_reg);
  assign is_hex    = dec[4];
  assign is_blank  = (on_reg == SEG_BLANK);
  assign cap_one   = cap_reg && (low_cnt == 4'd1);
  assign cap_multi = cap_reg && (low_cnt > 4'd1);

  logic update_reg;
  logic pattern_err_reg;
  logic sel_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      update_reg      <= 1'b0;
      pattern_err_reg <= 1'b0;
      sel_err_reg     <= 1'b0;
    end else begin
      update_reg      <= cap_one && (is_hex || is_blank);
      pattern_err_reg <= cap_one && !is_hex && !is_blank;
      sel_err_reg     <= cap_multi;
    end
  end

  assign update      = update_reg;
  assign pattern_err = pattern_err_reg;
  assign sel_err     = sel_err_reg;

  // ---------------------------------------------------------------------------
  // Per-digit result registers
  // ---------------------------------------------------------------------------
  logic [3:0] digit_reg [NUM_DIGITS];
  logic       valid_reg [NUM_DIGITS];
  logic       blank_reg [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic hit;
    assign hit = cap_one && (sel_idx == IW'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        digit_reg[gi] <= 4'h0;
        valid_reg[gi] <= 1'b0;
        blank_reg[gi] <= 1'b0;
      end else if (hit) begin
        if (is_hex) begin
          digit_reg[gi] <= dec[3:0];
          valid_reg[gi] <= 1'b1;
          blank_reg[gi] <= 1'b0;
        end else if (is_blank) begin
          // The last shown value is kept so the host can still read it.
          valid_reg[gi] <= 1'b0;
          blank_reg[gi] <= 1'b1;
        end
      end
    end

    assign digits_out[4*gi +: 4] = digit_reg[gi];
    assign digit_valid[gi]       = valid_reg[gi];
    assign digit_blank[gi]       = blank_reg[gi];
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Testbench for fnd_scan_decoder: directed scenarios followed by random bus
// traffic. A reference model watches the bus, predicts every pulse and the
// digit state that goes with it, and queues it; a monitor pops and compares.
module tb_fnd_scan_decoder;

  localparam int ND = 4;
  localparam int S  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ND-1:0]   fnd_sel = '1;
  logic [6:0]      fnd_on  = 7'h7F;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0]   digit_valid;
  logic [ND-1:0]   digit_blank;
  logic            update;
  logic            pattern_err;
  logic            sel_err;

  fnd_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .fnd_sel(fnd_sel), .fnd_on(fnd_on),
    .digits_out(digits_out), .digit_valid(digit_valid), .digit_blank(digit_blank),
    .update(update), .pattern_err(pattern_err), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Segment table, index = hex value.
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    int        cycle;
    int        kind;    // 0 update, 1 pattern_err, 2 sel_err
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  blank;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;

  // ---------------- reference model ----------------
  int          run_len = 0;
  logic [10:0] prev_bus = '1;
  logic [3:0]  m_dig [ND];
  logic [3:0]  m_valid = '0;
  logic [3:0]  m_blank = '0;

  function automatic logic [15:0] pack_digits();
    logic [15:0] r;
    for (int k = 0; k < ND; k++) r[4*k +: 4] = m_dig[k];
    return r;
  endfunction

  always @(posedge clk) begin
    logic [10:0] cur;
    int old_len, zeros, k, hexv;
    exp_t e;
    cyc++;
    if (rst) begin
      run_len  = 0;
      prev_bus = '1;
      for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
      m_valid = '0;
      m_blank = '0;
      sb.delete();
    end else begin
      cur = {fnd_sel, fnd_on};
      old_len = run_len;
      if (cur == prev_bus) run_len = (run_len < S) ? run_len + 1 : S;
      else run_len = 1;
      prev_bus = cur;
      if (old_len < S && run_len == S) begin
        zeros = ND - $countones(fnd_sel);
        e.cycle = cyc + 1;
        if (zeros >= 2) begin
          e.kind = 2;
        end else if (zeros == 1) begin
          k = 0;
          for (int i = 0; i < ND; i++) if (!fnd_sel[i]) k = i;
          hexv = -1;
          for (int h = 0; h < 16; h++) if (seg_tab[h] == fnd_on) hexv = h;
          if (hexv >= 0) begin
            m_dig[k] = 4'(hexv);
            m_valid[k] = 1'b1;
            m_blank[k] = 1'b0;
            e.kind = 0;
          end else if (fnd_on == 7'h7F) begin
            m_valid[k] = 1'b0;
            m_blank[k] = 1'b1;
            e.kind = 0;
          end else begin
            e.kind = 1;
          end
        end
        if (zeros >= 1) begin
          e.digits = pack_digits();
          e.valid  = m_valid;
          e.blank  = m_blank;
          sb.push_back(e);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int np, kind;
    exp_t e;
    np = int'(update === 1'b1) + int'(pattern_err === 1'b1) + int'(sel_err === 1'b1);
    kind = (update === 1'b1) ? 0 : (pattern_err === 1'b1) ? 1 : 2;
    if (np > 1) chk("one_pulse", np, 1);
    if (np > 0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected none", kind, cyc);
      end else begin
        e = sb.pop_front();
        $display("txn cycle=%0d kind=%0d digits=%h valid=%b blank=%b", cyc, kind, digits_out, digit_valid, digit_blank);
        chk("pulse_cycle", cyc, e.cycle);
        chk("pulse_kind", kind, e.kind);
        chk("digits_out", digits_out, e.digits);
        chk("digit_valid", digit_valid, e.valid);
        chk("digit_blank", digit_blank, e.blank);
      end
    end else if (sb.size() > 0 && sb[0].cycle <= cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing_pulse: got none at cycle %0d expected kind %0d at cycle %0d", cyc, e.kind, e.cycle);
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [ND-1:0] s, input logic [6:0] o, input int n);
    fnd_sel = s;
    fnd_on  = o;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ND-1:0] s;
    logic [6:0] o;
    int r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_digits", digits_out, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_blank", digit_blank, 0);
    chk("rst_pulses", {update, pattern_err, sel_err}, 0);
    rst = 1'b0;

    hold(4'b1111, 7'h7F, 20);
    chk("idle_digits", digits_out, 0);
    chk("idle_valid", digit_valid, 0);

    hold(4'b1110, 7'b0100100, 10);
    chk("d0_is_2", digits_out[3:0], 4'h2);
    chk("d0_valid", digit_valid, 4'b0001);

    hold(4'b1110, 7'b0000010, 6);
    hold(4'b1101, 7'b0000011, 6);
    hold(4'b1011, 7'b1000110, 6);
    hold(4'b0111, 7'b1111111, 6);
    chk("scan_digits", digits_out[11:0], 12'hCB6);
    chk("scan_valid", digit_valid, 4'b0111);
    chk("scan_blank", digit_blank, 4'b1000);

    hold(4'b1101, 7'b0100100, 3);
    hold(4'b1101, 7'b0110000, 5);
    chk("glitch_d1", digits_out[7:4], 4'h3);

    hold(4'b1110, 7'b1010101, 5);
    chk("perr_d0_kept", digits_out[3:0], 4'h6);
    hold(4'b1100, 7'b0100100, 5);
    chk("serr_digits_kept", digits_out[11:0], 12'hC36);

    // Reset two cycles into a window, then keep the same pattern.
    hold(4'b1011, 7'b0010000, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(4'b1011, 7'b0010000, 6);
    chk("rst_mid_digits", digits_out, 16'h0900);
    chk("rst_mid_valid", digit_valid, 4'b0100);
    chk("rst_mid_blank", digit_blank, 4'b0000);

    // Random traffic.
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7) s = ~(4'(1) << $urandom_range(0, ND - 1));
      else if (r == 7) s = 4'b1111;
      else s = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) o = seg_tab[$urandom_range(0, 15)];
      else if (r == 7) o = 7'h7F;
      else o = 7'($urandom);
      hold(s, o, $urandom_range(1, 8));
    end

    hold(4'b1111, 7'h7F, 10);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
